keypad_move_ctrl: RTL

KEYPAD_MOVE_CTRL -- requirements
Module: keypad_move_ctrl

---
 rtl/keypad_move_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_move_ctrl.sv
// keypad_move_ctrl: scans a 6-row keypad one row per scan_tick, reduces each
// six-row frame to a single key (or none), debounces it and issues one-cycle
// move/restart command pulses.
// Optional build macro KEYPAD_AUTO_REPEAT_EN adds auto-repeat while a key is
// held; without it a held key yields exactly one pulse per accept.
//
// state    | meaning
// IDLE     | no key accepted, waiting for a frame holding exactly one key
// DEBOUNCE | candidate key seen, counting consecutive identical frames
// PRESSED  | key accepted and still held (auto-repeat counts here)
// RELEASE  | accepted key vanished, counting empty frames before dropping it
module keypad_move_ctrl #(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_FRAMES   = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_tick,
    input  logic [2:0] column,
    output logic [2:0] sel,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_restart,
    output logic [3:0] keycode,
    output logic       key_held
);

    localparam logic [3:0] KEY_NONE    = 4'hF;
    localparam logic [3:0] KEY_UP      = 4'd2;
    localparam logic [3:0] KEY_LEFT    = 4'd4;
    localparam logic [3:0] KEY_RIGHT   = 4'd6;
    localparam logic [3:0] KEY_DOWN    = 4'd8;
    localparam logic [3:0] KEY_RESTART = 4'd0;

    localparam logic [4:0] DEB_LIMIT = 5'(DEBOUNCE_FRAMES);

    // Reject illegal parameter values at elaboration.
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
        $error("keypad_move_ctrl: DEBOUNCE_FRAMES must be 1..15");
    end
    if (REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_repeat
        $error("keypad_move_ctrl: REPEAT_FRAMES must be 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] keycode_nxt;
    logic [3:0] pulse_key;

    logic [3:0] scan_key;
    logic [3:0] acc_key;
    logic       acc_multi;
    logic [3:0] merged_key;
    logic       merged_multi;
    logic [3:0] frame_key;
    logic       frame_end;

    logic       start_deb;
    logic [3:0] start_key;
    logic       do_accept;
    logic [3:0] accept_key;

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam logic [8:0] RPT_LIMIT = 9'(REPEAT_FRAMES);
    logic [7:0] rpt, rpt_nxt;
`endif

    // Decode the column returns against the row currently selected.
    always_comb begin
        scan_key = KEY_NONE;
        case (sel)
            3'd0: if (column == 3'b101) scan_key = KEY_UP;
            3'd1: begin
                if (column == 3'b011)      scan_key = KEY_LEFT;
                else if (column == 3'b110) scan_key = KEY_RIGHT;
            end
            3'd2: if (column == 3'b101) scan_key = KEY_DOWN;
            3'd3: if (column == 3'b101) scan_key = KEY_RESTART;
            default: ;
        endcase
    end

    // Fold this tick's key into the frame so far; two distinct keys poison the frame.
    always_comb begin
        merged_key   = acc_key;
        merged_multi = acc_multi;
        if (scan_key != KEY_NONE) begin
            if (acc_key == KEY_NONE) begin
                merged_key = scan_key;
            end else if (acc_key != scan_key) begin
                merged_multi = 1'b1;
            end
        end
    end

    assign frame_end = scan_tick && (sel == 3'd5);
    assign frame_key = merged_multi ? KEY_NONE : merged_key;
    assign key_held  = (state == ST_PRESSED) || (state == ST_RELEASE);

    // Row counter and frame accumulator; the accumulator restarts with every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= 3'd0;
            acc_key   <= KEY_NONE;
            acc_multi <= 1'b0;
        end else if (scan_tick) begin
            if (sel == 3'd5) begin
                sel       <= 3'd0;
                acc_key   <= KEY_NONE;
                acc_multi <= 1'b0;
            end else begin
                sel       <= sel + 3'd1;
                acc_key   <= merged_key;
                acc_multi <= merged_multi;
            end
        end
    end

    // Next-state and pulse selection, evaluated only on the frame-end tick.
    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand;
        cnt_nxt     = cnt;
        keycode_nxt = keycode;
        pulse_key   = KEY_NONE;
        start_deb   = 1'b0;
        start_key   = KEY_NONE;
        do_accept   = 1'b0;
        accept_key  = KEY_NONE;
`ifdef KEYPAD_AUTO_REPEAT_EN
        rpt_nxt     = rpt;
`endif

        if (frame_end) begin
            case (state)
                ST_IDLE: begin
                    if (frame_key != KEY_NONE) begin
                        start_deb = 1'b1;
                        start_key = frame_key;
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_key == KEY_NONE) begin
                        state_nxt = ST_IDLE;
                        cand_nxt  = KEY_NONE;
                        cnt_nxt   = 4'd0;
                    end else if (frame_key == cand) begin
                        if (({1'b0, cnt} + 5'd1) >= DEB_LIMIT) begin
                            do_accept  = 1'b1;
                            accept_key = cand;
                        end else begin
                            cnt_nxt = cnt + 4'd1;
                        end
                    end else begin
                        start_deb = 1'b1;
                        start_key = frame_key;
                    end
                end
                ST_PRESSED: begin
                    if (frame_key == cand) begin
`ifdef KEYPAD_AUTO_REPEAT_EN
                        // Restart is a one-shot command and must never repeat.
                        if (cand != KEY_RESTART) begin
                            if (({1'b0, rpt} + 9'd1) == RPT_LIMIT) begin
                                pulse_key = cand;
                                rpt_nxt   = 8'd0;
                            end else begin
                                rpt_nxt = rpt + 8'd1;
                            end
                        end
`endif
                    end else begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (frame_key == KEY_NONE) begin
                        if (({1'b0, cnt} + 5'd1) >= DEB_LIMIT) begin
                            state_nxt   = ST_IDLE;
                            keycode_nxt = KEY_NONE;
                            cand_nxt    = KEY_NONE;
                            cnt_nxt     = 4'd0;
                        end else begin
                            cnt_nxt = cnt + 4'd1;
                        end
                    end else if (frame_key == cand) begin
                        // Bounce of the held key: resume holding without a new pulse.
                        state_nxt = ST_PRESSED;
                        cnt_nxt   = 4'd0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                        rpt_nxt   = 8'd0;
`endif
                    end else begin
                        start_deb = 1'b1;
                        start_key = frame_key;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // A single-frame debounce accepts on the first sighting.
        if (start_deb) begin
            if (DEBOUNCE_FRAMES <= 1) begin
                do_accept  = 1'b1;
                accept_key = start_key;
            end else begin
                state_nxt = ST_DEBOUNCE;
                cand_nxt  = start_key;
                cnt_nxt   = 4'd1;
            end
        end

        if (do_accept) begin
            state_nxt   = ST_PRESSED;
            cand_nxt    = accept_key;
            cnt_nxt     = 4'd0;
            keycode_nxt = accept_key;
            pulse_key   = accept_key;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rpt_nxt     = 8'd0;
`endif
        end
    end

    // State, keycode and registered one-cycle command pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= KEY_NONE;
            cnt         <= 4'd0;
            keycode     <= KEY_NONE;
            key_up      <= 1'b0;
            key_down    <= 1'b0;
            key_left    <= 1'b0;
            key_right   <= 1'b0;
            key_restart <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            cnt         <= cnt_nxt;
            keycode     <= keycode_nxt;
            key_up      <= (pulse_key == KEY_UP);
            key_down    <= (pulse_key == KEY_DOWN);
            key_left    <= (pulse_key == KEY_LEFT);
            key_right   <= (pulse_key == KEY_RIGHT);
            key_restart <= (pulse_key == KEY_RESTART);
        end
    end

`ifdef KEYPAD_AUTO_REPEAT_EN
    // Held-frame counter for auto-repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt <= 8'd0;
        end else begin
            rpt <= rpt_nxt;
        end
    end
`endif

endmodule
